// File: rtl/noc_traffic_pe.sv
// rtl/noc_traffic_pe.sv - HNoC traffic endpoint: pattern/rate packet generator plus latency-checking sink
module noc_traffic_pe #(
    parameter int          address      = 0,
    parameter int          numPE        = 4,
    parameter int          AddressWidth = 2,
    parameter int          DataWidth    = 32,
    parameter int          TotalWidth   = 34,
    parameter int          PktLimit     = 100,
    parameter int          Pattern      = 0,
    parameter int          InjRate      = 256,
    parameter logic [15:0] Seed         = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    output logic [TotalWidth-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    input  logic [TotalWidth-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_tx_done,
    output logic [31:0]           o_rx_count,
    output logic [47:0]           o_lat_sum,
    output logic [31:0]           o_lat_max,
    output logic                  o_err
);

    localparam int SW = DataWidth - AddressWidth;

    localparam logic [AddressWidth-1:0] SRC          = AddressWidth'(address);
    localparam logic [AddressWidth-1:0] DEST_TORNADO = AddressWidth'((address + numPE/2 - 1) % numPE);
    localparam logic [AddressWidth-1:0] DEST_BITCOMP = ~SRC;
    localparam logic [AddressWidth-1:0] DEST_NEIGH   = SRC + AddressWidth'(1);
    localparam logic [8:0]              RATE         = 9'(InjRate);
    localparam logic [15:0]             SENT_LAST    = 16'(PktLimit - 1);
    localparam logic [15:0]             LFSR_INIT    = Seed ^ 16'(address);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           cnt_q, cnt_d;
    logic [7:0]              acc_q, acc_d;
    logic                    pend_q, pend_d;
    logic [TotalWidth-1:0]   data_q, data_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [15:0]             sent_q, sent_d;
    logic [31:0]             rx_cnt_q, rx_cnt_d;
    logic [47:0]             lat_sum_q, lat_sum_d;
    logic [31:0]             lat_max_q, lat_max_d;
    logic                    err_q, err_d;

    logic                    hs, last_hs, inj, form;
    logic [8:0]              acc_sum;
    logic [15:0]             lfsr_step;
    logic [AddressWidth-1:0] rand_dest, dest, rx_dest;
    logic [SW-1:0]           lat_raw;
    logic [31:0]             lat32;
    logic [48:0]             sum_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            pend_q    <= 1'b0;
            data_q    <= '0;
            lfsr_q    <= LFSR_INIT;
            sent_q    <= '0;
            rx_cnt_q  <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            lfsr_q    <= lfsr_d;
            sent_q    <= sent_d;
            rx_cnt_q  <= rx_cnt_d;
            lat_sum_q <= lat_sum_d;
            lat_max_q <= lat_max_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        hs      = pend_q & i_data_ready;
        last_hs = hs && (sent_q == SENT_LAST);
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_enable) state_d = S_RUN;
            S_RUN:   if (last_hs) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // A handshake frees the slot in the same cycle, so full rate stays back to back.
    always_comb begin
        cnt_d     = cnt_q + SW'(1);
        inj       = (state_q == S_RUN) && i_enable && (!pend_q || hs) && !last_hs;
        acc_sum   = {1'b0, acc_q} + RATE;
        form      = inj && acc_sum[8];
        acc_d     = inj ? acc_sum[7:0] : acc_q;
        pend_d    = form ? 1'b1 : (hs ? 1'b0 : pend_q);
        lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        rand_dest = lfsr_step[AddressWidth-1:0];
        if (rand_dest == SRC) rand_dest = SRC + AddressWidth'(1);
        case (Pattern)
            0:       dest = DEST_TORNADO;
            1:       dest = DEST_BITCOMP;
            2:       dest = DEST_NEIGH;
            default: dest = rand_dest;
        endcase
        lfsr_d = (form && Pattern == 3) ? lfsr_step : lfsr_q;
        data_d = form ? {dest, SRC, cnt_d} : data_q;
        sent_d = hs ? sent_q + 16'd1 : sent_q;
    end

    // Latency is taken modulo the timestamp width; the subtraction spans the whole
    // payload and the cast keeps only the timestamp bits.
    always_comb begin
        rx_dest   = i_data[TotalWidth-1 -: AddressWidth];
        lat_raw   = SW'({{AddressWidth{1'b0}}, cnt_q} - i_data[DataWidth-1:0]);
        lat32     = 32'(lat_raw);
        sum_ext   = {1'b0, lat_sum_q} + 49'(lat_raw);
        rx_cnt_d  = rx_cnt_q;
        lat_sum_d = lat_sum_q;
        lat_max_d = lat_max_q;
        err_d     = err_q;
        if (i_data_valid) begin
            if (rx_cnt_q != 32'hFFFF_FFFF) rx_cnt_d = rx_cnt_q + 32'd1;
            lat_sum_d = sum_ext[48] ? {48{1'b1}} : sum_ext[47:0];
            if (lat32 > lat_max_q) lat_max_d = lat32;
            if (rx_dest != SRC) err_d = 1'b1;
        end
    end

    always_comb begin
        o_tx_done    = (state_q == S_DONE);
        o_data_valid = pend_q;
        o_data       = data_q;
        o_data_ready = ~rst;
        o_rx_count   = rx_cnt_q;
        o_lat_sum    = lat_sum_q;
        o_lat_max    = lat_max_q;
        o_err        = err_q;
    end

endmodule

// File: tb/tb_noc_traffic_pe.sv
// tb/tb_noc_traffic_pe.sv - directed self-checking bench for noc_traffic_pe
module tb_noc_traffic_pe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        en0, rdy0, ival0, oval0, ordy0, done0, err0;
    logic [33:0] idata0, odata0;
    logic [31:0] rxc0, lmax0;
    logic [47:0] lsum0;

    logic        en1, rdy1, ival1, oval1, ordy1, done1, err1;
    logic [33:0] idata1, odata1;
    logic [31:0] rxc1, lmax1;
    logic [47:0] lsum1;

    logic        en2, rdy2, ival2, oval2, ordy2, done2, err2;
    logic [33:0] idata2, odata2;
    logic [31:0] rxc2, lmax2;
    logic [47:0] lsum2;

    logic        en3, rdy3, ival3, oval3, ordy3, done3, err3;
    logic [32:0] idata3, odata3;
    logic [31:0] rxc3, lmax3;
    logic [47:0] lsum3;

    logic [149:0] outs0;
    assign outs0 = {odata0, oval0, ordy0, done0, rxc0, lsum0, lmax0, err0};

    noc_traffic_pe #(.address(0), .numPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(34),
                     .PktLimit(100), .Pattern(0), .InjRate(256), .Seed(16'hACE1)) u0 (
        .clk(clk), .rst(rst), .i_enable(en0), .o_data(odata0), .o_data_valid(oval0),
        .i_data_ready(rdy0), .i_data(idata0), .i_data_valid(ival0), .o_data_ready(ordy0),
        .o_tx_done(done0), .o_rx_count(rxc0), .o_lat_sum(lsum0), .o_lat_max(lmax0), .o_err(err0));

    noc_traffic_pe #(.address(0), .numPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(34),
                     .PktLimit(100), .Pattern(2), .InjRate(64), .Seed(16'hACE1)) u1 (
        .clk(clk), .rst(rst), .i_enable(en1), .o_data(odata1), .o_data_valid(oval1),
        .i_data_ready(rdy1), .i_data(idata1), .i_data_valid(ival1), .o_data_ready(ordy1),
        .o_tx_done(done1), .o_rx_count(rxc1), .o_lat_sum(lsum1), .o_lat_max(lmax1), .o_err(err1));

    noc_traffic_pe #(.address(2), .numPE(4), .AddressWidth(2), .DataWidth(32), .TotalWidth(34),
                     .PktLimit(1000), .Pattern(3), .InjRate(256), .Seed(16'hACE1)) u2 (
        .clk(clk), .rst(rst), .i_enable(en2), .o_data(odata2), .o_data_valid(oval2),
        .i_data_ready(rdy2), .i_data(idata2), .i_data_valid(ival2), .o_data_ready(ordy2),
        .o_tx_done(done2), .o_rx_count(rxc2), .o_lat_sum(lsum2), .o_lat_max(lmax2), .o_err(err2));

    noc_traffic_pe #(.address(0), .numPE(2), .AddressWidth(1), .DataWidth(32), .TotalWidth(33),
                     .PktLimit(10), .Pattern(0), .InjRate(256), .Seed(16'hACE1)) u3 (
        .clk(clk), .rst(rst), .i_enable(en3), .o_data(odata3), .o_data_valid(oval3),
        .i_data_ready(rdy3), .i_data(idata3), .i_data_valid(ival3), .o_data_ready(ordy3),
        .o_tx_done(done3), .o_rx_count(rxc3), .o_lat_sum(lsum3), .o_lat_max(lmax3), .o_err(err3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en0 = 0; en1 = 0; en2 = 0; en3 = 0;
        rdy0 = 1; rdy1 = 1; rdy2 = 1; rdy3 = 1;
        ival0 = 0; ival1 = 0; ival2 = 0; ival3 = 0;
        idata0 = '0; idata1 = '0; idata2 = '0; idata3 = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b1;
        tick;
        n_tests++;
        if (outs0 !== 150'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs0);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (ordy0 !== 1'b1 || oval0 !== 1'b0 || done0 !== 1'b0 || rxc0 !== 32'd0) begin
            n_fail++; $display("FAIL reset_release: ready=%b valid=%b done=%b rx=%0d expected 1 0 0 0",
                               ordy0, oval0, done0, rxc0);
        end
    endtask

    task automatic test_tornado_burst;
        int nvalid, first_v, last_v, done_at, bad_fields, bad_ts;
        logic [29:0] prev_ts;
        nvalid = 0; first_v = -1; last_v = -1; done_at = -1; bad_fields = 0; bad_ts = 0; prev_ts = '0;
        do_reset;
        tick;
        en0 = 1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            tick;
            if (done0 && done_at < 0) done_at = cyc;
            if (oval0) begin
                if (odata0[33:32] !== 2'd1 || odata0[31:30] !== 2'd0) bad_fields++;
                if (nvalid > 0 && (odata0[29:0] !== prev_ts + 30'd1 || cyc != last_v + 1)) bad_ts++;
                if (first_v < 0) first_v = cyc;
                prev_ts = odata0[29:0];
                last_v = cyc;
                nvalid++;
            end
        end
        n_tests++;
        if (first_v != 2) begin n_fail++; $display("FAIL tornado_first_latency: got %0d expected 2", first_v); end
        n_tests++;
        if (nvalid != 100) begin n_fail++; $display("FAIL tornado_count: got %0d expected 100", nvalid); end
        n_tests++;
        if (bad_fields != 0) begin n_fail++; $display("FAIL tornado_dest_src: got %0d bad expected 0", bad_fields); end
        n_tests++;
        if (bad_ts != 0) begin n_fail++; $display("FAIL tornado_back_to_back: got %0d gaps expected 0", bad_ts); end
        n_tests++;
        if (done_at != 102) begin n_fail++; $display("FAIL tornado_tx_done: got cycle %0d expected 102", done_at); end
    endtask

    task automatic test_backpressure;
        logic [33:0] d;
        int w;
        do_reset;
        rdy0 = 0;
        tick;
        en0 = 1;
        w = 0;
        while (!oval0 && w < 10) begin tick; w++; end
        n_tests++;
        if (oval0 !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 1", oval0); end
        d = odata0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            n_tests++;
            if (oval0 !== 1'b1 || odata0 !== d) begin
                n_fail++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/%h", k, oval0, odata0, d);
            end
            if (k == 5) rdy0 = 1;
        end
        tick;
        n_tests++;
        if (oval0 !== 1'b1 || odata0[29:0] !== d[29:0] + 30'd6) begin
            n_fail++; $display("FAIL bp_accept_6th: got %b/%h expected 1/%h", oval0, odata0[29:0], d[29:0] + 30'd6);
        end
        d = odata0;
        rdy0 = 0;
        en0 = 0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            n_tests++;
            if (oval0 !== 1'b1 || odata0 !== d) begin
                n_fail++; $display("FAIL bp_disable_hold_%0d: got %b/%h expected 1/%h", k, oval0, odata0, d);
            end
        end
        rdy0 = 1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            n_tests++;
            if (oval0 !== 1'b0) begin n_fail++; $display("FAIL bp_disable_stop_%0d: got %b expected 0", k, oval0); end
        end
    endtask

    task automatic test_rate;
        int n, prev, gaps_bad, bad_dest, first_v, last_v;
        n = 0; prev = 0; gaps_bad = 0; bad_dest = 0; first_v = -1; last_v = -1;
        do_reset;
        tick;
        en1 = 1;
        for (int cyc = 1; cyc <= 600 && !done1; cyc++) begin
            tick;
            if (oval1) begin
                if (n > 0 && cyc - prev != 4) gaps_bad++;
                if (odata1[33:32] !== 2'd1) bad_dest++;
                if (first_v < 0) first_v = cyc;
                prev = cyc;
                last_v = cyc;
                n++;
            end
        end
        n_tests++;
        if (n != 100) begin n_fail++; $display("FAIL rate_count: got %0d expected 100", n); end
        n_tests++;
        if (gaps_bad != 0) begin n_fail++; $display("FAIL rate_spacing: got %0d bad gaps expected 0", gaps_bad); end
        n_tests++;
        if (first_v != 5) begin n_fail++; $display("FAIL rate_first: got cycle %0d expected 5", first_v); end
        n_tests++;
        if (last_v < 396 || last_v > 404) begin n_fail++; $display("FAIL rate_span: got %0d expected 400+-4", last_v); end
        n_tests++;
        if (bad_dest != 0 || done1 !== 1'b1) begin
            n_fail++; $display("FAIL rate_dest_done: got %0d bad dest, done=%b expected 0, 1", bad_dest, done1);
        end
    endtask

    // The self-address remap folds the LFSR's address quarter into address+1,
    // so dest 3 collects about half the traffic for address 2.
    task automatic test_uniform;
        int cnt[4];
        int n, bad_model, bad_src;
        logic [15:0] m;
        logic [1:0] d;
        n = 0; bad_model = 0; bad_src = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        m = 16'hACE1 ^ 16'd2;
        do_reset;
        tick;
        en2 = 1;
        for (int cyc = 1; cyc <= 1100 && !done2; cyc++) begin
            tick;
            if (oval2) begin
                m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
                d = m[1:0];
                if (d == 2'd2) d = 2'd3;
                if (odata2[33:32] !== d) bad_model++;
                if (odata2[31:30] !== 2'd2) bad_src++;
                cnt[odata2[33:32]]++;
                n++;
            end
        end
        n_tests++;
        if (n != 1000) begin n_fail++; $display("FAIL uniform_count: got %0d expected 1000", n); end
        n_tests++;
        if (cnt[2] != 0) begin n_fail++; $display("FAIL uniform_self: got %0d expected 0", cnt[2]); end
        n_tests++;
        if (bad_model != 0 || bad_src != 0) begin
            n_fail++; $display("FAIL uniform_sequence: got %0d dest/%0d src errors expected 0", bad_model, bad_src);
        end
        n_tests++;
        if (cnt[0] < 190 || cnt[0] > 310 || cnt[1] < 190 || cnt[1] > 310 || cnt[3] < 440 || cnt[3] > 560) begin
            n_fail++; $display("FAIL uniform_spread: got %0d %0d %0d expected 250 250 500 +-60", cnt[0], cnt[1], cnt[3]);
        end
    endtask

    task automatic test_loopback;
        logic        pv[10];
        logic [32:0] pd[10];
        logic        cur_v;
        logic [32:0] cur_d;
        for (int i = 0; i < 10; i++) begin pv[i] = 0; pd[i] = '0; end
        do_reset;
        tick;
        en3 = 1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick;
            cur_v = oval3 & rdy3;
            cur_d = odata3;
            ival3 = pv[9];
            idata3 = pd[9];
            for (int i = 9; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
            pv[0] = cur_v;
            pd[0] = cur_d;
        end
        n_tests++;
        if (rxc3 !== 32'd10) begin n_fail++; $display("FAIL loop_rx_count: got %0d expected 10", rxc3); end
        n_tests++;
        if (lsum3 !== 48'd100) begin n_fail++; $display("FAIL loop_lat_sum: got %0d expected 100", lsum3); end
        n_tests++;
        if (lmax3 !== 32'd10) begin n_fail++; $display("FAIL loop_lat_max: got %0d expected 10", lmax3); end
        n_tests++;
        if (err3 !== 1'b0 || done3 !== 1'b1) begin
            n_fail++; $display("FAIL loop_err_done: got err=%b done=%b expected 0 1", err3, done3);
        end
    endtask

    task automatic test_misroute_reset;
        do_reset;
        tick;
        en0 = 1;
        repeat (5) tick;
        idata0 = {2'd3, 2'd1, 30'd7};
        ival0 = 1;
        tick;
        ival0 = 0;
        n_tests++;
        if (err0 !== 1'b1 || rxc0 !== 32'd1) begin
            n_fail++; $display("FAIL misroute_err: got err=%b rx=%0d expected 1 1", err0, rxc0);
        end
        repeat (3) tick;
        n_tests++;
        if (err0 !== 1'b1) begin n_fail++; $display("FAIL misroute_sticky: got %b expected 1", err0); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (outs0 !== 150'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %h expected 0", outs0); end
        tick;
        rst = 1'b0;
        en0 = 0;
        repeat (3) tick;
        n_tests++;
        if (oval0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || rxc0 !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_quiet: got v=%b d=%b e=%b rx=%0d expected 0 0 0 0", oval0, done0, err0, rxc0);
        end
        en0 = 1;
        tick;
        n_tests++;
        if (oval0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_step: got %b expected 0", oval0); end
        tick;
        n_tests++;
        if (oval0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_restart: got %b expected 1", oval0); end
    endtask

    initial begin
        test_reset;
        test_tornado_burst;
        test_backpressure;
        test_rate;
        test_uniform;
        test_loopback;
        test_misroute_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
